// File: rtl/ldm_stm_pkg.sv
// Shared definitions for the LDM/STM multi-register transfer sequencer.
package ldm_stm_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StXfer = 2'd1,
        StWb   = 2'd2
    } state_e;

    // Encoded as {P, U}.
    typedef enum logic [1:0] {
        AmDa = 2'b00,
        AmIa = 2'b01,
        AmDb = 2'b10,
        AmIb = 2'b11
    } amode_e;

    localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/first_one_16.sv
// Index of the least-significant set bit of a 16-bit vector; 0 when empty.
module first_one_16 (
    input  logic [15:0] i_vec,
    output logic [3:0]  o_idx
);

    always_comb begin
        o_idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (i_vec[i]) begin
                o_idx = 4'(i);
            end
        end
    end

endmodule

// File: rtl/reg_popcount.sv
// Counts set bits in a 16-bit register list.
module reg_popcount (
    input  logic [15:0] i_mask,
    output logic [4:0]  o_count
);

    always_comb begin
        o_count = '0;
        for (int i = 0; i < 16; i++) begin
            o_count = o_count + 5'(i_mask[i]);
        end
    end

endmodule

// File: rtl/ldm_stm_sequencer.sv
// LDM/STM sequencer: one register transfer per acked beat, optional base writeback.
// Optional user-bank support is enabled by defining LDMSTM_USER_BANK_EN.
module ldm_stm_sequencer
    import ldm_stm_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    output logic              o_ready,
    input  logic [15:0]       i_reg_list,
    input  logic [ADDR_W-1:0] i_base,
    input  logic              i_p,
    input  logic              i_u,
    input  logic              i_wback,
    input  logic              i_load,
    input  logic              i_s_bit,
    output logic              o_valid,
    input  logic              i_ack,
    input  logic              i_abort,
    output logic [3:0]        o_reg_idx,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_load,
    output logic              o_last,
    output logic              o_user_bank,
    output logic              o_wb_valid,
    output logic [ADDR_W-1:0] o_wb_addr,
    output logic              o_done,
    output logic              o_aborted
);

    state_e            state_q, state_d;
    logic [15:0]       mask_q, mask_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
    logic              wback_q, wback_d;
    logic              load_q, load_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;

    logic [4:0]        count;
    logic [3:0]        first_idx;
    logic [ADDR_W-1:0] n4;
    logic [ADDR_W-1:0] word;
    logic [ADDR_W-1:0] start_addr;
    logic              accept;
    logic              last;
    amode_e            amode;

    reg_popcount u_popcount (
        .i_mask  (i_reg_list),
        .o_count (count)
    );

    first_one_16 u_first_one (
        .i_vec (mask_q),
        .o_idx (first_idx)
    );

    // Ready drops during the done pulse so a new sequence starts only after it.
    assign o_ready = (state_q == StIdle) && !done_q;
    assign accept  = i_start && o_ready;
    assign last    = $onehot(mask_q);
    assign n4      = ADDR_W'({count, 2'b00});
    assign word    = ADDR_W'(WORD_BYTES);
    assign amode   = amode_e'({i_p, i_u});

    always_comb begin
        start_addr = i_base;
        unique case (amode)
            AmIa:    start_addr = i_base;
            AmIb:    start_addr = i_base + word;
            AmDa:    start_addr = i_base - n4 + word;
            AmDb:    start_addr = i_base - n4;
            default: start_addr = i_base;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mask_d    = mask_q;
        addr_d    = addr_q;
        wb_addr_d = wb_addr_q;
        wback_d   = wback_q;
        load_d    = load_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mask_d    = i_reg_list;
                    addr_d    = start_addr;
                    wb_addr_d = i_u ? (i_base + n4) : (i_base - n4);
                    wback_d   = i_wback;
                    load_d    = i_load;
                    if (i_reg_list == 16'h0000) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StXfer;
                    end
                end
            end
            StXfer: begin
                if (i_abort) begin
                    state_d   = StIdle;
                    done_d    = 1'b1;
                    aborted_d = 1'b1;
                end else if (i_ack) begin
                    mask_d = mask_q & (mask_q - 16'd1);
                    addr_d = addr_q + word;
                    if (last) begin
                        if (wback_q) begin
                            state_d = StWb;
                        end else begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                        end
                    end
                end
            end
            StWb: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            mask_q    <= '0;
            addr_q    <= '0;
            wb_addr_q <= '0;
            wback_q   <= 1'b0;
            load_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            addr_q    <= addr_d;
            wb_addr_q <= wb_addr_d;
            wback_q   <= wback_d;
            load_q    <= load_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign o_valid    = (state_q == StXfer);
    assign o_reg_idx  = o_valid ? first_idx : 4'd0;
    assign o_addr     = addr_q;
    assign o_last     = o_valid && last;
    assign o_load     = load_q;
    assign o_wb_valid = (state_q == StWb);
    assign o_wb_addr  = wb_addr_q;
    assign o_done     = done_q;
    assign o_aborted  = aborted_q;

`ifdef LDMSTM_USER_BANK_EN
    logic s_q, s_d;
    logic r15_q, r15_d;

    always_comb begin
        s_d   = s_q;
        r15_d = r15_q;
        if (accept) begin
            s_d   = i_s_bit;
            r15_d = i_reg_list[15];
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_q   <= 1'b0;
            r15_q <= 1'b0;
        end else begin
            s_q   <= s_d;
            r15_q <= r15_d;
        end
    end

    // LDM with r15 in the list is an exception return and keeps the current bank.
    assign o_user_bank = o_valid && s_q && (!load_q || !r15_q);
`else
    logic unused_s_bit;
    assign unused_s_bit = i_s_bit;
    assign o_user_bank  = 1'b0;
`endif

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Directed self-checking bench for ldm_stm_sequencer.
module tb_ldm_stm_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        ready;
    logic [15:0] reg_list;
    logic [31:0] base;
    logic        p, u, wback, load, s_bit;
    logic        valid;
    logic        ack;
    logic        abort_i;
    logic [3:0]  reg_idx;
    logic [31:0] addr;
    logic        load_o;
    logic        last;
    logic        user_bank;
    logic        wb_valid;
    logic [31:0] wb_addr;
    logic        done;
    logic        aborted;

    int n_cmp = 0;
    int n_err = 0;

`ifdef LDMSTM_USER_BANK_EN
    localparam bit UbEn = 1'b1;
`else
    localparam bit UbEn = 1'b0;
`endif

    ldm_stm_sequencer #(.ADDR_W(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_start     (start),
        .o_ready     (ready),
        .i_reg_list  (reg_list),
        .i_base      (base),
        .i_p         (p),
        .i_u         (u),
        .i_wback     (wback),
        .i_load      (load),
        .i_s_bit     (s_bit),
        .o_valid     (valid),
        .i_ack       (ack),
        .i_abort     (abort_i),
        .o_reg_idx   (reg_idx),
        .o_addr      (addr),
        .o_load      (load_o),
        .o_last      (last),
        .o_user_bank (user_bank),
        .o_wb_valid  (wb_valid),
        .o_wb_addr   (wb_addr),
        .o_done      (done),
        .o_aborted   (aborted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_seq(input logic [15:0] l, input logic [31:0] b, input logic pp,
                             input logic uu, input logic w, input logic ld, input logic s);
        reg_list = l;
        base     = b;
        p        = pp;
        u        = uu;
        wback    = w;
        load     = ld;
        s_bit    = s;
        start    = 1'b1;
        step();
        start    = 1'b0;
        reg_list = 16'h0;
        base     = 32'h0;
    endtask

    task automatic check_beat(input string tag, input logic [3:0] idx, input logic [31:0] a,
                              input logic lst);
        check_eq({tag, ".valid"}, 64'(valid), 64'd1);
        check_eq({tag, ".idx"}, 64'(reg_idx), 64'(idx));
        check_eq({tag, ".addr"}, 64'(addr), 64'(a));
        check_eq({tag, ".last"}, 64'(last), 64'(lst));
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, ".ready"}, 64'(ready), 64'd1);
        check_eq({tag, ".valid"}, 64'(valid), 64'd0);
        check_eq({tag, ".idx"}, 64'(reg_idx), 64'd0);
        check_eq({tag, ".addr"}, 64'(addr), 64'd0);
        check_eq({tag, ".last"}, 64'(last), 64'd0);
        check_eq({tag, ".load"}, 64'(load_o), 64'd0);
        check_eq({tag, ".ubank"}, 64'(user_bank), 64'd0);
        check_eq({tag, ".wbv"}, 64'(wb_valid), 64'd0);
        check_eq({tag, ".wba"}, 64'(wb_addr), 64'd0);
        check_eq({tag, ".done"}, 64'(done), 64'd0);
        check_eq({tag, ".abrt"}, 64'(aborted), 64'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; reg_list = '0; base = '0;
        p = 0; u = 0; wback = 0; load = 0; s_bit = 0; ack = 0; abort_i = 0;
        step();
        step();
        check_idle_outputs("reset");
        rst = 1'b0;
        step();

        // IA with writeback.
        ack = 1'b1;
        start_seq(16'h000A, 32'h1000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_beat("ia.b0", 4'd1, 32'h1000, 1'b0);
        check_eq("ia.ready", 64'(ready), 64'd0);
        step();
        check_beat("ia.b1", 4'd3, 32'h1004, 1'b1);
        step();
        check_eq("ia.wbv", 64'(wb_valid), 64'd1);
        check_eq("ia.wba", 64'(wb_addr), 64'h1008);
        check_eq("ia.novalid", 64'(valid), 64'd0);
        step();
        check_eq("ia.done", 64'(done), 64'd1);
        check_eq("ia.abrt", 64'(aborted), 64'd0);
        check_eq("ia.wbv_off", 64'(wb_valid), 64'd0);
        check_eq("ia.ready_lo", 64'(ready), 64'd0);
        step();
        check_eq("ia.ready_hi", 64'(ready), 64'd1);
        check_eq("ia.done_off", 64'(done), 64'd0);

        // DB, LDM with r15 and S set: user bank stays off.
        start_seq(16'h8001, 32'h2000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        check_beat("db.b0", 4'd0, 32'h1FF8, 1'b0);
        check_eq("db.load", 64'(load_o), 64'd1);
        check_eq("db.ubank", 64'(user_bank), 64'd0);
        step();
        check_beat("db.b1", 4'd15, 32'h1FFC, 1'b1);
        step();
        check_eq("db.wbv", 64'(wb_valid), 64'd1);
        check_eq("db.wba", 64'(wb_addr), 64'h1FF8);
        step();
        check_eq("db.done", 64'(done), 64'd1);
        step();

        // IB wrapping through zero.
        start_seq(16'h0003, 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        check_beat("wrap.b0", 4'd0, 32'h0000_0000, 1'b0);
        step();
        check_beat("wrap.b1", 4'd1, 32'h0000_0004, 1'b1);
        step();
        check_eq("wrap.wbv", 64'(wb_valid), 64'd1);
        check_eq("wrap.wba", 64'(wb_addr), 64'h4);
        step();
        check_eq("wrap.done", 64'(done), 64'd1);
        step();

        // DA without writeback: start = base - 4*3 + 4.
        start_seq(16'h0124, 32'h0000_0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check_beat("da.b0", 4'd2, 32'h0000_00F8, 1'b0);
        step();
        check_beat("da.b1", 4'd5, 32'h0000_00FC, 1'b0);
        step();
        check_beat("da.b2", 4'd8, 32'h0000_0100, 1'b1);
        step();
        check_eq("da.done", 64'(done), 64'd1);
        check_eq("da.nowb", 64'(wb_valid), 64'd0);
        step();

        // Stall on the second beat for three cycles.
        start_seq(16'h0007, 32'h3000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        check_beat("stall.b0", 4'd0, 32'h3000, 1'b0);
        step();
        check_beat("stall.b1", 4'd1, 32'h3004, 1'b0);
        ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_beat($sformatf("stall.hold%0d", i), 4'd1, 32'h3004, 1'b0);
        end
        ack = 1'b1;
        step();
        check_beat("stall.b2", 4'd2, 32'h3008, 1'b1);
        step();
        check_eq("stall.done", 64'(done), 64'd1);
        step();

        // Empty list.
        start_seq(16'h0000, 32'h5555, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_eq("empty.done", 64'(done), 64'd1);
        check_eq("empty.valid", 64'(valid), 64'd0);
        check_eq("empty.wbv", 64'(wb_valid), 64'd0);
        step();
        check_eq("empty.done_off", 64'(done), 64'd0);
        check_eq("empty.ready", 64'(ready), 64'd1);
        check_eq("empty.wbv2", 64'(wb_valid), 64'd0);

        // Abort on the second of three beats; abort wins over ack.
        start_seq(16'h0070, 32'h4000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check_beat("abort.b0", 4'd4, 32'h4000, 1'b0);
        step();
        check_beat("abort.b1", 4'd5, 32'h4004, 1'b0);
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        check_eq("abort.valid", 64'(valid), 64'd0);
        check_eq("abort.wbv", 64'(wb_valid), 64'd0);
        check_eq("abort.done", 64'(done), 64'd1);
        check_eq("abort.flag", 64'(aborted), 64'd1);
        step();
        check_eq("abort.ready", 64'(ready), 64'd1);
        check_eq("abort.valid2", 64'(valid), 64'd0);
        check_eq("abort.wbv2", 64'(wb_valid), 64'd0);
        check_eq("abort.flag_off", 64'(aborted), 64'd0);

        // STM with S set uses the user bank; then reset mid-transfer.
        start_seq(16'h8001, 32'h6000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check_beat("rst.b0", 4'd0, 32'h6000, 1'b0);
        check_eq("rst.ubank", 64'(user_bank), 64'(UbEn));
        rst = 1'b1;
        ack = 1'b0;
        step();
        check_idle_outputs("midrst");
        rst = 1'b0;
        ack = 1'b1;
        step();
        check_eq("midrst.done", 64'(done), 64'd0);
        check_eq("midrst.wbv", 64'(wb_valid), 64'd0);
        check_eq("midrst.valid", 64'(valid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
